// File: rtl/vector_multi_reduce_unit_if.sv
// Data/config bus of the vector reduce unit: master drives vectors and config,
// slave (the unit) returns reduced vectors aligned with eof and chain id.
interface vector_multi_reduce_unit_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4
);
  localparam int CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;

  logic                           valid_in;
  logic                           eof_in;
  logic [CW-1:0]                  chainId_in;
  logic                           tracing;
  logic [7:0]                     configId;
  logic [7:0]                     configData;
  logic [N-1:0][DATA_WIDTH-1:0]   vector_in;
  logic                           valid_out;
  logic [N-1:0][DATA_WIDTH-1:0]   vector_out;
  logic                           eof_out;
  logic [CW-1:0]                  chainId_out;

  modport master (
    output valid_in, eof_in, chainId_in, tracing, configId, configData, vector_in,
    input  valid_out, vector_out, eof_out, chainId_out
  );

  modport slave (
    input  valid_in, eof_in, chainId_in, tracing, configId, configData, vector_in,
    output valid_out, vector_out, eof_out, chainId_out
  );
endinterface

// File: rtl/vector_multi_reduce_unit.sv
// Pipelined per-chain vector reducer: pass, sum, max, min, group sum and
// cross-vector accumulate, one registered tree level per cycle.
module vector_multi_reduce_unit #(
  parameter int                    N                  = 8,
  parameter int                    DATA_WIDTH         = 32,
  parameter int                    M                  = 2,
  parameter int                    MAX_CHAINS         = 4,
  parameter logic [7:0]            PERSONAL_CONFIG_ID = 8'd0,
  parameter logic [MAX_CHAINS*8-1:0] INITIAL_FIRMWARE = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  vector_multi_reduce_unit_if.slave  bus
);
  localparam int LV  = $clog2(N);
  localparam int GLV = $clog2(N / M);
  localparam int CW  = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
  localparam logic [8:0] CHAINS9 = 9'(MAX_CHAINS);

  localparam logic [2:0] MODE_SUM   = 3'd1;
  localparam logic [2:0] MODE_MAX   = 3'd2;
  localparam logic [2:0] MODE_MIN   = 3'd3;
  localparam logic [2:0] MODE_GROUP = 3'd4;
  localparam logic [2:0] MODE_ACC   = 3'd5;

  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

  // One tree level: pairs (2i, 2i+1) fold into lane i; group mode stops folding
  // once each group has collapsed to a single lane. Other codes pass through.
  function automatic vec_t reduce_level(input vec_t d, input logic [2:0] mode, input int lvl);
    vec_t                  r;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  combine;
    combine = (mode == MODE_SUM) || (mode == MODE_MAX) || (mode == MODE_MIN) ||
              (mode == MODE_ACC) || ((mode == MODE_GROUP) && (lvl <= GLV));
    r = d;
    if (combine) begin
      r = '0;
      for (int i = 0; i < N / 2; i++) begin
        if (i < (N >> lvl)) begin
          a = d[2*i];
          b = d[2*i+1];
          if (mode == MODE_MAX)      r[i] = ($signed(a) > $signed(b)) ? a : b;
          else if (mode == MODE_MIN) r[i] = ($signed(a) < $signed(b)) ? a : b;
          else                       r[i] = a + b;
        end
      end
    end
    return r;
  endfunction

  logic [7:0]            firmware_reg [MAX_CHAINS];
  logic [DATA_WIDTH-1:0] acc_reg      [MAX_CHAINS];

  vec_t          data_reg  [LV];
  logic [2:0]    mode_reg  [LV];
  logic [CW-1:0] chain_reg [LV];
  logic          valid_reg [LV];
  logic          eof_reg   [LV];
  vec_t          level_next [1:LV];

  logic [8:0]            cfg_offset;
  logic                  cfg_hit;
  logic [CW-1:0]         cfg_idx;
  logic [DATA_WIDTH-1:0] acc_sum;
  vec_t                  acc_vec;

  assign cfg_offset = {1'b0, bus.configId} - {1'b0, PERSONAL_CONFIG_ID};
  assign cfg_hit    = !bus.tracing && (bus.configId >= PERSONAL_CONFIG_ID) && (cfg_offset < CHAINS9);
  assign cfg_idx    = cfg_offset[CW-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_CHAINS; i++) firmware_reg[i] <= INITIAL_FIRMWARE[i*8 +: 8];
    end else if (cfg_hit) begin
      firmware_reg[cfg_idx] <= bus.configData;
    end
  end

  // Stage 0: the mode is latched here so reconfiguration never affects in-flight vectors.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg[0] <= 1'b0;
      eof_reg[0]   <= 1'b0;
      chain_reg[0] <= '0;
      mode_reg[0]  <= '0;
    end else begin
      valid_reg[0] <= bus.valid_in & bus.tracing;
      eof_reg[0]   <= bus.eof_in;
      chain_reg[0] <= bus.chainId_in;
      mode_reg[0]  <= firmware_reg[bus.chainId_in][2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (bus.valid_in && bus.tracing) data_reg[0] <= bus.vector_in;
  end

  generate
    for (genvar gi = 1; gi < LV; gi++) begin : g_stage
      always_comb level_next[gi] = reduce_level(data_reg[gi-1], mode_reg[gi-1], gi);

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          valid_reg[gi] <= 1'b0;
          eof_reg[gi]   <= 1'b0;
          chain_reg[gi] <= '0;
          mode_reg[gi]  <= '0;
        end else begin
          valid_reg[gi] <= valid_reg[gi-1];
          eof_reg[gi]   <= eof_reg[gi-1];
          chain_reg[gi] <= chain_reg[gi-1];
          mode_reg[gi]  <= mode_reg[gi-1];
        end
      end

      always_ff @(posedge clk) begin
        if (valid_reg[gi-1]) data_reg[gi] <= level_next[gi];
      end
    end
  endgenerate

  always_comb begin
    level_next[LV] = reduce_level(data_reg[LV-1], mode_reg[LV-1], LV);
    acc_sum        = acc_reg[chain_reg[LV-1]] + level_next[LV][0];
    acc_vec        = '0;
    acc_vec[0]     = acc_sum;
  end

  // Final level doubles as the output register; accumulate beats only surface on eof.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.valid_out   <= 1'b0;
      bus.eof_out     <= 1'b0;
      bus.chainId_out <= '0;
      bus.vector_out  <= '0;
      for (int i = 0; i < MAX_CHAINS; i++) acc_reg[i] <= '0;
    end else begin
      bus.valid_out <= 1'b0;
      bus.eof_out   <= 1'b0;
      if (valid_reg[LV-1]) begin
        if (mode_reg[LV-1] == MODE_ACC) begin
          if (eof_reg[LV-1]) begin
            bus.valid_out             <= 1'b1;
            bus.eof_out               <= 1'b1;
            bus.chainId_out           <= chain_reg[LV-1];
            bus.vector_out            <= acc_vec;
            acc_reg[chain_reg[LV-1]] <= '0;
          end else begin
            acc_reg[chain_reg[LV-1]] <= acc_sum;
          end
        end else begin
          bus.valid_out   <= 1'b1;
          bus.eof_out     <= eof_reg[LV-1];
          bus.chainId_out <= chain_reg[LV-1];
          bus.vector_out  <= level_next[LV];
        end
      end
      if (cfg_hit) acc_reg[cfg_idx] <= '0;
    end
  end
endmodule

// File: tb/tb_vector_multi_reduce_unit.sv
// Directed scoreboard bench for vector_multi_reduce_unit (N=8, M=2, 32-bit lanes).
module tb_vector_multi_reduce_unit;
  localparam int N      = 8;
  localparam int DW     = 32;
  localparam int CHAINS = 4;
  localparam int LAT    = 4;

  typedef logic [N-1:0][DW-1:0] vec_t;
  typedef struct {
    vec_t       vec;
    logic       eof;
    logic [1:0] chain;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  vector_multi_reduce_unit_if #(.N(N), .DATA_WIDTH(DW), .MAX_CHAINS(CHAINS)) bus();

  vector_multi_reduce_unit #(
    .N(N), .DATA_WIDTH(DW), .M(2), .MAX_CHAINS(CHAINS),
    .PERSONAL_CONFIG_ID(8'd0), .INITIAL_FIRMWARE(32'h0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t v8(input int a0, input int a1, input int a2, input int a3,
                              input int a4, input int a5, input int a6, input int a7);
    vec_t r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
    return r;
  endfunction

  function automatic vec_t mk(input int s);
    return v8(s - 7, 1, 1, 1, 1, 1, 1, 1);
  endfunction

  function automatic vec_t one(input int x);
    return v8(x, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic chk(input string tag, input vec_t got, input vec_t exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("valid_out", vec_t'(bus.valid_out), vec_t'(1'b1));
      chk("vector_out", bus.vector_out, e.vec);
      chk("eof_out", vec_t'(bus.eof_out), vec_t'(e.eof));
      chk("chainId_out", vec_t'(bus.chainId_out), vec_t'(e.chain));
    end else begin
      chk("bubble_valid", vec_t'(bus.valid_out), vec_t'(1'b0));
      chk("bubble_eof", vec_t'(bus.eof_out), vec_t'(1'b0));
    end
    $display("[TB] cyc %0d valid_out=%0b eof_out=%0b chain=%0d lane0=%h lane1=%h",
             cyc, bus.valid_out, bus.eof_out, bus.chainId_out, bus.vector_out[0], bus.vector_out[1]);
  endtask

  task automatic send(input vec_t v, input logic eof, input logic [1:0] ch,
                      input logic expect_out, input vec_t ev);
    bus.valid_in   = 1'b1;
    bus.tracing    = 1'b1;
    bus.eof_in     = eof;
    bus.chainId_in = ch;
    bus.vector_in  = v;
    if (expect_out) sb.push_back('{ev, eof, ch, cyc + LAT});
    tick();
  endtask

  task automatic idle(input int n);
    bus.valid_in = 1'b0;
    bus.eof_in   = 1'b0;
    repeat (n) tick();
  endtask

  // Config cycles also present a valid vector, which must be dropped.
  task automatic cfg(input logic [7:0] id, input logic [7:0] data);
    bus.tracing    = 1'b0;
    bus.valid_in   = 1'b1;
    bus.eof_in     = 1'b1;
    bus.chainId_in = 2'd0;
    bus.vector_in  = v8(99, 98, 97, 96, 95, 94, 93, 92);
    bus.configId   = id;
    bus.configData = data;
    tick();
    bus.tracing  = 1'b1;
    bus.valid_in = 1'b0;
    bus.configId = 8'hFF;
  endtask

  initial begin
    bus.valid_in   = 1'b0;
    bus.eof_in     = 1'b0;
    bus.chainId_in = 2'd0;
    bus.tracing    = 1'b1;
    bus.configId   = 8'hFF;
    bus.configData = 8'h00;
    bus.vector_in  = '0;

    #1;
    chk("reset_valid", vec_t'(bus.valid_out), vec_t'(1'b0));
    chk("reset_eof", vec_t'(bus.eof_out), vec_t'(1'b0));
    chk("reset_chain", vec_t'(bus.chainId_out), vec_t'(2'd0));
    chk("reset_vector", bus.vector_out, '0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Default firmware is pass-through on every chain
    send(v8(1, 2, 3, 4, 5, 6, 7, 8), 1'b1, 2'd0, 1'b1, v8(1, 2, 3, 4, 5, 6, 7, 8));
    send(v8(9, 10, 11, 12, 13, 14, 15, 16), 1'b0, 2'd2, 1'b1, v8(9, 10, 11, 12, 13, 14, 15, 16));
    idle(5);

    // Out-of-range config id must not touch chain 0
    cfg(8'd4, 8'd1);
    send(v8(1, 2, 3, 4, 5, 6, 7, 8), 1'b0, 2'd0, 1'b1, v8(1, 2, 3, 4, 5, 6, 7, 8));
    idle(5);

    cfg(8'd0, 8'd1);
    cfg(8'd1, 8'd2);
    cfg(8'd2, 8'd3);
    cfg(8'd3, 8'd4);
    send(v8(1, 2, 3, 4, 5, 6, 7, 8), 1'b0, 2'd0, 1'b1, one(36));
    send(v8(-1, -1, -1, -1, -1, -1, -1, -1), 1'b1, 2'd0, 1'b1, one(-8));
    send(v8(-5, 3, 7, -9, 0, 2, 7, 1), 1'b0, 2'd1, 1'b1, one(7));
    send(v8(-5, 3, 7, -9, 0, 2, 7, 1), 1'b1, 2'd2, 1'b1, one(-9));
    send(v8(1, 2, 3, 4, 5, 6, 7, 8), 1'b0, 2'd3, 1'b1, v8(10, 26, 0, 0, 0, 0, 0, 0));
    send(v8(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
            32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF),
         1'b1, 2'd3, 1'b1, v8(-4, -4, 0, 0, 0, 0, 0, 0));
    idle(6);

    // Interleaved per-chain accumulation; only eof beats are visible
    cfg(8'd0, 8'd5);
    cfg(8'd3, 8'd5);
    send(mk(10), 1'b0, 2'd0, 1'b0, '0);
    send(mk(5),  1'b0, 2'd3, 1'b0, '0);
    send(mk(20), 1'b0, 2'd0, 1'b0, '0);
    send(mk(7),  1'b1, 2'd3, 1'b1, one(12));
    send(mk(30), 1'b1, 2'd0, 1'b1, one(60));
    send(mk(4),  1'b1, 2'd0, 1'b1, one(4));
    idle(6);

    // Reconfigure chain 0 while its pass-through vector is in flight
    cfg(8'd0, 8'd0);
    send(v8(8, 7, 6, 5, 4, 3, 2, 1), 1'b0, 2'd0, 1'b1, v8(8, 7, 6, 5, 4, 3, 2, 1));
    cfg(8'd0, 8'd1);
    send(v8(1, 2, 3, 4, 5, 6, 7, 8), 1'b1, 2'd0, 1'b1, one(36));
    idle(6);

    // Reset while outputs are streaming
    for (int i = 0; i < 5; i++) send(v8(i, 1, 1, 1, 1, 1, 1, 1), 1'b0, 2'd0, 1'b1, one(i + 7));
    reset_n = 1'b0;
    #1;
    chk("midreset_valid", vec_t'(bus.valid_out), vec_t'(1'b0));
    chk("midreset_vector", bus.vector_out, '0);
    sb.delete();
    bus.valid_in = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    idle(6);

    // Firmware returned to its reset value: chain 3 passes through again
    send(v8(1, 2, 3, 4, 5, 6, 7, 8), 1'b1, 2'd3, 1'b1, v8(1, 2, 3, 4, 5, 6, 7, 8));
    idle(6);

    chk("scoreboard_drained", vec_t'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
